// File: rtl/mig_rw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mig_rw_arbiter
//  Description : Arbitrates a single MIG user interface between a frame-buffer
//                write engine (video source -> DDR) and a read engine
//                (DDR -> display). Issues one burst request at a time and
//                tracks per-direction frame offsets. Completed frames
//                ping-pong between two frame buffers.
//
//  Ports
//    ui_clk, ui_clk_sync_rst          : MIG user clock and its sync reset
//    init_calib_complete              : no request is issued while low
//    wr_fifo_cnt / wr_frame_start     : source FIFO level, new-frame pulse
//    rd_fifo_space / rd_frame_start   : sink FIFO space, new-frame pulse
//    wr_req/wr_req_addr/wr_length     : write-engine request (1-cycle pulse)
//    wr_busy/wr_done                  : write-engine status / completion pulse
//    rd_req/rd_req_addr/rd_length     : read-engine request (1-cycle pulse)
//    rd_busy/rd_done                  : read-engine status / completion pulse
//    wr_bank/rd_bank                  : buffer currently written / read
//    frame_valid                      : at least one complete frame stored
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mig_rw_arbiter #(
    parameter int unsigned  BURST_LEN   = 64,
    parameter int unsigned  FRAME_BEATS = 61440,
    parameter int unsigned  ADDR_STEP   = 8,
    parameter logic [27:0]  FB0_BASE    = 28'h000_0000,
    parameter logic [27:0]  FB1_BASE    = 28'h080_0000
) (
    input  logic        ui_clk,
    input  logic        ui_clk_sync_rst,
    input  logic        init_calib_complete,

    input  logic [15:0] wr_fifo_cnt,
    input  logic        wr_frame_start,
    input  logic [15:0] rd_fifo_space,
    input  logic        rd_frame_start,

    output logic        wr_req,
    output logic [27:0] wr_req_addr,
    output logic [15:0] wr_length,
    input  logic        wr_busy,
    input  logic        wr_done,

    output logic        rd_req,
    output logic [27:0] rd_req_addr,
    output logic [15:0] rd_length,
    input  logic        rd_busy,
    input  logic        rd_done,

    output logic        wr_bank,
    output logic        rd_bank,
    output logic        frame_valid
);

    localparam logic [15:0] c_burst     = 16'(BURST_LEN);
    localparam logic [15:0] c_frame     = 16'(FRAME_BEATS);
    localparam logic [27:0] c_addr_step = 28'(ADDR_STEP);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4
    } state_t;

    state_t      r_state;
    logic [15:0] r_wr_ofs;
    logic [15:0] r_rd_ofs;
    logic        r_done_bank;      // bank holding the newest complete frame
    logic        r_last_rd;        // 1: last grant went to the read engine
    logic        r_wr_start_pend;  // wr_frame_start seen while a write is out
    logic        r_rd_start_pend;  // rd_frame_start seen while a read is out

    // ------------------------------------------------------------------------
    // Burst length and eligibility per direction
    // ------------------------------------------------------------------------
    logic [15:0] w_wr_remain;
    logic [15:0] w_rd_remain;
    logic [15:0] w_wr_len;
    logic [15:0] w_rd_len;
    logic        w_wr_elig;
    logic        w_rd_elig;

    // Remainder is only meaningful while the offset is below the frame size;
    // eligibility masks it otherwise.
    assign w_wr_remain = c_frame - r_wr_ofs;
    assign w_rd_remain = c_frame - r_rd_ofs;
    assign w_wr_len    = (w_wr_remain < c_burst) ? w_wr_remain : c_burst;
    assign w_rd_len    = (w_rd_remain < c_burst) ? w_rd_remain : c_burst;

    assign w_wr_elig = (r_wr_ofs < c_frame) && (wr_fifo_cnt >= w_wr_len);
    assign w_rd_elig = frame_valid && (r_rd_ofs < c_frame)
                       && (rd_fifo_space >= w_rd_len);

    // ------------------------------------------------------------------------
    // Grant decision (evaluated in IDLE only)
    // ------------------------------------------------------------------------
    logic w_can_issue;
    logic w_grant_wr;
    logic w_grant_rd;

    assign w_can_issue = (r_state == IDLE) && init_calib_complete
                         && !wr_busy && !rd_busy;
    // With both eligible the direction not served last wins.
    assign w_grant_wr  = w_can_issue && w_wr_elig && (!w_rd_elig || r_last_rd);
    assign w_grant_rd  = w_can_issue && w_rd_elig && (!w_wr_elig || !r_last_rd);

    // A request counts as in flight from the grant cycle onward, so a
    // frame-start pulse arriving then must be deferred to the done cycle.
    logic w_wr_inflight;
    logic w_rd_inflight;

    assign w_wr_inflight = w_grant_wr || (r_state == WR_REQ) || (r_state == WR_WAIT);
    assign w_rd_inflight = w_grant_rd || (r_state == RD_REQ) || (r_state == RD_WAIT);

    // ------------------------------------------------------------------------
    // Request addresses (28-bit, wrap on overflow)
    // ------------------------------------------------------------------------
    logic [27:0] w_wr_base;
    logic [27:0] w_rd_base;
    logic [27:0] w_wr_addr;
    logic [27:0] w_rd_addr;

    assign w_wr_base = wr_bank ? FB1_BASE : FB0_BASE;
    assign w_rd_base = rd_bank ? FB1_BASE : FB0_BASE;
    assign w_wr_addr = w_wr_base + (28'(r_wr_ofs) * c_addr_step);
    assign w_rd_addr = w_rd_base + (28'(r_rd_ofs) * c_addr_step);

    // ------------------------------------------------------------------------
    // Completion bookkeeping
    // ------------------------------------------------------------------------
    logic        w_wr_done_acc;
    logic        w_rd_done_acc;
    logic [15:0] w_wr_ofs_sum;
    logic [15:0] w_rd_ofs_sum;
    logic        w_frame_done;
    logic        w_done_bank_nxt;

    // Done pulses outside the matching wait state are discarded here.
    assign w_wr_done_acc = (r_state == WR_WAIT) && wr_done;
    assign w_rd_done_acc = (r_state == RD_WAIT) && rd_done;

    // Offset + length never exceeds the frame size, so 16 bits suffice.
    assign w_wr_ofs_sum  = r_wr_ofs + wr_length;
    assign w_rd_ofs_sum  = r_rd_ofs + rd_length;

    assign w_frame_done    = w_wr_done_acc && (w_wr_ofs_sum == c_frame);
    // A read frame start coinciding with a frame completion must pick up the
    // freshly completed bank.
    assign w_done_bank_nxt = w_frame_done ? wr_bank : r_done_bank;

    // ------------------------------------------------------------------------
    // Sequential logic: FSM, registered outputs, offsets and banks
    // ------------------------------------------------------------------------
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_state         <= IDLE;
            wr_req          <= 1'b0;
            wr_req_addr     <= 28'd0;
            wr_length       <= 16'd0;
            rd_req          <= 1'b0;
            rd_req_addr     <= 28'd0;
            rd_length       <= 16'd0;
            r_wr_ofs        <= 16'd0;
            r_rd_ofs        <= c_frame;     // reads parked until a frame start
            wr_bank         <= 1'b0;
            rd_bank         <= 1'b1;
            r_done_bank     <= 1'b1;
            frame_valid     <= 1'b0;
            r_last_rd       <= 1'b1;
            r_wr_start_pend <= 1'b0;
            r_rd_start_pend <= 1'b0;
        end else begin
            // ---------------- FSM and request outputs ----------------
            case (r_state)
                IDLE: begin
                    if (w_grant_wr) begin
                        r_state     <= WR_REQ;
                        wr_req      <= 1'b1;
                        wr_req_addr <= w_wr_addr;
                        wr_length   <= w_wr_len;
                    end else if (w_grant_rd) begin
                        r_state     <= RD_REQ;
                        rd_req      <= 1'b1;
                        rd_req_addr <= w_rd_addr;
                        rd_length   <= w_rd_len;
                    end
                end
                WR_REQ: begin
                    wr_req    <= 1'b0;
                    r_last_rd <= 1'b0;
                    r_state   <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (wr_done) begin
                        r_state <= IDLE;
                    end
                end
                RD_REQ: begin
                    rd_req    <= 1'b0;
                    r_last_rd <= 1'b1;
                    r_state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (rd_done) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    wr_req  <= 1'b0;
                    rd_req  <= 1'b0;
                end
            endcase

            // ---------------- write offset / bank ----------------
            if (w_wr_done_acc) begin
                if (r_wr_start_pend || wr_frame_start) begin
                    r_wr_ofs <= 16'd0;
                end else begin
                    r_wr_ofs <= w_wr_ofs_sum;
                end
                r_wr_start_pend <= 1'b0;
            end else if (wr_frame_start) begin
                if (w_wr_inflight) begin
                    r_wr_start_pend <= 1'b1;
                end else begin
                    // Also abandons a partial frame: the bank is kept.
                    r_wr_ofs <= 16'd0;
                end
            end

            if (w_frame_done) begin
                r_done_bank <= wr_bank;
                wr_bank     <= ~wr_bank;
                frame_valid <= 1'b1;
            end

            // ---------------- read offset / bank ----------------
            if (w_rd_done_acc) begin
                if (r_rd_start_pend || rd_frame_start) begin
                    r_rd_ofs <= 16'd0;
                    rd_bank  <= w_done_bank_nxt;
                end else begin
                    r_rd_ofs <= w_rd_ofs_sum;
                end
                r_rd_start_pend <= 1'b0;
            end else if (rd_frame_start) begin
                if (w_rd_inflight) begin
                    r_rd_start_pend <= 1'b1;
                end else begin
                    r_rd_ofs <= 16'd0;
                    rd_bank  <= w_done_bank_nxt;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mig_rw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mig_rw_arbiter
//  Description : Directed self-checking bench for mig_rw_arbiter, built with
//                FRAME_BEATS=100 so a frame spans a 64-beat and a 36-beat
//                burst. Engines are emulated step by step.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mig_rw_arbiter;

    logic        ui_clk = 1'b0;
    logic        ui_clk_sync_rst;
    logic        init_calib_complete;
    logic [15:0] wr_fifo_cnt;
    logic        wr_frame_start;
    logic [15:0] rd_fifo_space;
    logic        rd_frame_start;
    logic        wr_req;
    logic [27:0] wr_req_addr;
    logic [15:0] wr_length;
    logic        wr_busy;
    logic        wr_done;
    logic        rd_req;
    logic [27:0] rd_req_addr;
    logic [15:0] rd_length;
    logic        rd_busy;
    logic        rd_done;
    logic        wr_bank;
    logic        rd_bank;
    logic        frame_valid;

    int checks = 0;
    int passed = 0;

    mig_rw_arbiter #(
        .BURST_LEN   (64),
        .FRAME_BEATS (100),
        .ADDR_STEP   (8),
        .FB0_BASE    (28'h000_0000),
        .FB1_BASE    (28'h080_0000)
    ) dut (
        .ui_clk              (ui_clk),
        .ui_clk_sync_rst     (ui_clk_sync_rst),
        .init_calib_complete (init_calib_complete),
        .wr_fifo_cnt         (wr_fifo_cnt),
        .wr_frame_start      (wr_frame_start),
        .rd_fifo_space       (rd_fifo_space),
        .rd_frame_start      (rd_frame_start),
        .wr_req              (wr_req),
        .wr_req_addr         (wr_req_addr),
        .wr_length           (wr_length),
        .wr_busy             (wr_busy),
        .wr_done             (wr_done),
        .rd_req              (rd_req),
        .rd_req_addr         (rd_req_addr),
        .rd_length           (rd_length),
        .rd_busy             (rd_busy),
        .rd_done             (rd_done),
        .wr_bank             (wr_bank),
        .rd_bank             (rd_bank),
        .frame_valid         (frame_valid)
    );

    always #5 ui_clk = ~ui_clk;

    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_wr_req"},      32'(wr_req),      32'd0);
        chk({tag, "_rd_req"},      32'(rd_req),      32'd0);
        chk({tag, "_wr_addr"},     32'(wr_req_addr), 32'd0);
        chk({tag, "_wr_len"},      32'(wr_length),   32'd0);
        chk({tag, "_rd_addr"},     32'(rd_req_addr), 32'd0);
        chk({tag, "_rd_len"},      32'(rd_length),   32'd0);
        chk({tag, "_wr_bank"},     32'(wr_bank),     32'd0);
        chk({tag, "_rd_bank"},     32'(rd_bank),     32'd1);
        chk({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
    endtask

    // Entered in the cycle where wr_req is high; leaves the DUT back in IDLE
    // right after the done edge.
    task automatic wr_complete();
        wr_busy = 1'b1;
        tick();
        chk("wr_req_one_cycle", 32'(wr_req), 32'd0);
        chk("no_rd_while_wr", 32'(rd_req), 32'd0);
        tick();
        wr_done = 1'b1;
        wr_busy = 1'b0;
        tick();
        wr_done = 1'b0;
    endtask

    task automatic rd_complete();
        rd_busy = 1'b1;
        tick();
        chk("rd_req_one_cycle", 32'(rd_req), 32'd0);
        chk("no_wr_while_rd", 32'(wr_req), 32'd0);
        tick();
        rd_done = 1'b1;
        rd_busy = 1'b0;
        tick();
        rd_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ui_clk_sync_rst     = 1'b1;
        init_calib_complete = 1'b0;
        wr_fifo_cnt         = 16'd0;
        wr_frame_start      = 1'b0;
        rd_fifo_space       = 16'd0;
        rd_frame_start      = 1'b0;
        wr_busy             = 1'b0;
        wr_done             = 1'b0;
        rd_busy             = 1'b0;
        rd_done             = 1'b0;
        tick();
        tick();
        chk_reset("reset");

        // Calibration gate
        ui_clk_sync_rst = 1'b0;
        wr_fifo_cnt     = 16'd100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("calib_gate_wr_req", 32'(wr_req), 32'd0);
        end
        init_calib_complete = 1'b1;
        tick();
        chk("calib_wr_req",  32'(wr_req),      32'd1);
        chk("calib_wr_addr", 32'(wr_req_addr), 32'd0);
        chk("calib_wr_len",  32'(wr_length),   32'd64);
        wr_complete();
        chk("idle_after_done", 32'(wr_req), 32'd0);

        // Frame wrap: second burst is the 36-beat tail
        tick();
        chk("tail_wr_req",  32'(wr_req),      32'd1);
        chk("tail_wr_addr", 32'(wr_req_addr), 32'd512);
        chk("tail_wr_len",  32'(wr_length),   32'd36);
        chk("tail_wr_bank", 32'(wr_bank),     32'd0);
        wr_complete();
        chk("wrap_wr_bank",     32'(wr_bank),     32'd1);
        chk("wrap_frame_valid", 32'(frame_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wrap_no_more_req", 32'({wr_req, rd_req}), 32'd0);
        end

        // Read bank selection and sink-space gating
        rd_fifo_space  = 16'd10;
        rd_frame_start = 1'b1;
        tick();
        rd_frame_start = 1'b0;
        chk("rd_start_bank", 32'(rd_bank), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rd_space_gate", 32'(rd_req), 32'd0);
        end
        rd_fifo_space = 16'd64;
        tick();
        chk("rd_req",  32'(rd_req),      32'd1);
        chk("rd_addr", 32'(rd_req_addr), 32'h000_0000);
        chk("rd_len",  32'(rd_length),   32'd64);

        // Read completes; restart writes (now on bank 1) in the same cycle
        rd_busy = 1'b1;
        tick();
        chk("rd_req_one_cycle", 32'(rd_req), 32'd0);
        tick();
        rd_done        = 1'b1;
        rd_busy        = 1'b0;
        wr_frame_start = 1'b1;
        tick();
        rd_done        = 1'b0;
        wr_frame_start = 1'b0;

        // Round-robin: last grant was RD, so WR, then RD
        tick();
        chk("rr1_wr_req",  32'(wr_req),      32'd1);
        chk("rr1_rd_req",  32'(rd_req),      32'd0);
        chk("rr1_wr_addr", 32'(wr_req_addr), 32'h080_0000);
        chk("rr1_wr_len",  32'(wr_length),   32'd64);
        wr_complete();
        tick();
        chk("rr2_rd_req",  32'(rd_req),      32'd1);
        chk("rr2_wr_req",  32'(wr_req),      32'd0);
        chk("rr2_rd_addr", 32'(rd_req_addr), 32'h000_0200);
        chk("rr2_rd_len",  32'(rd_length),   32'd36);
        rd_complete();
        tick();
        chk("rr3_wr_req",  32'(wr_req),      32'd1);
        chk("rr3_wr_addr", 32'(wr_req_addr), 32'h080_0200);
        chk("rr3_wr_len",  32'(wr_length),   32'd36);

        // Frame completion on bank 1 coincides with a read frame start
        wr_busy = 1'b1;
        tick();
        tick();
        wr_done        = 1'b1;
        wr_busy        = 1'b0;
        rd_frame_start = 1'b1;
        rd_fifo_space  = 16'd0;
        tick();
        wr_done        = 1'b0;
        rd_frame_start = 1'b0;
        chk("coinc_wr_bank", 32'(wr_bank),     32'd0);
        chk("coinc_rd_bank", 32'(rd_bank),     32'd1);
        chk("coinc_valid",   32'(frame_valid), 32'd1);

        // New source frame on bank 0, then a start latched during WR_WAIT
        wr_frame_start = 1'b1;
        tick();
        wr_frame_start = 1'b0;
        tick();
        chk("b0_wr_req",  32'(wr_req),      32'd1);
        chk("b0_wr_addr", 32'(wr_req_addr), 32'h000_0000);
        wr_busy = 1'b1;
        tick();
        wr_frame_start = 1'b1;
        tick();
        wr_frame_start = 1'b0;
        tick();
        wr_done = 1'b1;
        wr_busy = 1'b0;
        tick();
        wr_done = 1'b0;
        tick();
        chk("latched_wr_req",  32'(wr_req),      32'd1);
        chk("latched_wr_addr", 32'(wr_req_addr), 32'h000_0000);
        chk("latched_wr_len",  32'(wr_length),   32'd64);
        chk("latched_wr_bank", 32'(wr_bank),     32'd0);

        // Reset in the middle of a write burst
        wr_busy = 1'b1;
        tick();
        ui_clk_sync_rst = 1'b1;
        tick();
        chk_reset("midrst");

        // Stray done pulses in IDLE and WR_REQ are ignored
        ui_clk_sync_rst = 1'b0;
        wr_busy         = 1'b0;
        wr_done         = 1'b1;
        tick();
        chk("postrst_wr_req",  32'(wr_req),      32'd1);
        chk("postrst_wr_addr", 32'(wr_req_addr), 32'd0);
        chk("postrst_wr_len",  32'(wr_length),   32'd64);
        tick();
        wr_done = 1'b0;
        tick();
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        tick();
        chk("stray_done_wr_req",  32'(wr_req),      32'd1);
        chk("stray_done_wr_addr", 32'(wr_req_addr), 32'd512);
        chk("stray_done_wr_len",  32'(wr_length),   32'd36);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
